// File: rtl/frame_uploader_mb.sv
// Frame uploader: syncs on a frame-start marker in a show-ahead pixel queue, packs pixel pairs into
// burst words and writes each burst into a round-robin frame buffer. Optional statistics: FRAME_UPLOADER_STATS_EN.
module frame_uploader_mb #(
  parameter int PIXEL_W      = 16,
  parameter int BURST_WORDS  = 8,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int NUM_BUFFERS  = 2,
  parameter int ADDR_W       = 21,
  parameter int TCMD         = 19
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    buf_stride,
  input  logic                 queue_empty,
  input  logic [PIXEL_W:0]     queue_data,
  output logic                 rd_en,
  output logic                 write_rq,
  input  logic                 write_ack,
  output logic [ADDR_W-1:0]    write_addr,
  output logic                 mem_wr_en,
  output logic [2*PIXEL_W-1:0] write_data,
  output logic                 upload_done,
  output logic [2:0]           done_buf,
  output logic                 frame_error,
  output logic [15:0]          frames_ok,
  output logic [15:0]          frames_aborted,
  output logic [2:0]           dbg_state
);
  localparam int WORD_W = 2 * PIXEL_W;
  localparam int SLOTS  = 2 * BURST_WORDS;
  localparam int TOTAL  = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int WIDX_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam int CNT_W  = $clog2(TOTAL + 1);
  localparam int TCNT_W = (TCMD > 1) ? $clog2(TCMD) : 1;

  // IDLE encodes as 0 so dbg_state reads 0 out of reset.
  typedef enum logic [2:0] {IDLE, SYNC, FILL, REQ, DATA, TAIL, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [2:0]          cur_buf_q, cur_buf_d;
  logic [2:0]          done_buf_q, done_buf_d;
  logic [PIXEL_W-1:0]  cache_q [SLOTS];
  logic [PIXEL_W-1:0]  cache_d [SLOTS];
  logic [WORD_W-1:0]   word_sel;
  logic                marker;

  assign marker     = queue_data[PIXEL_W];
  assign word_sel   = {cache_q[SLOT_W'({widx_q, 1'b1})], cache_q[SLOT_W'({widx_q, 1'b0})]};
  assign write_addr = addr_q;
  assign dbg_state  = state_q;

  // Memory handshake: write_rq raises a request and is held until write_ack is seen; after the ack
  // write_rq stays high through the data beats and the command tail, then drops for one or more cycles.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    base_d      = base_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;
    widx_d      = widx_q;
    tcnt_d      = tcnt_q;
    cur_buf_d   = cur_buf_q;
    done_buf_d  = done_buf_q;
    cache_d     = cache_q;
    rd_en       = 1'b0;
    write_rq    = 1'b0;
    mem_wr_en   = 1'b0;
    write_data  = '0;
    upload_done = 1'b0;
    frame_error = 1'b0;
    done_buf    = done_buf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr + ADDR_W'(cur_buf_q) * buf_stride;
          addr_d  = base_addr + ADDR_W'(cur_buf_q) * buf_stride;
          state_d = SYNC;
        end
      end
      SYNC: begin
        rd_en = !queue_empty;
        if (!queue_empty && marker) begin
          cnt_d   = '0;
          slot_d  = '0;
          for (int i = 0; i < SLOTS; i++) cache_d[i] = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        rd_en = !queue_empty;
        if (!queue_empty) begin
          if (marker) begin
            // A new marker mid-frame abandons the partial frame and restarts it at the buffer base.
            frame_error = 1'b1;
            cnt_d       = '0;
            slot_d      = '0;
            addr_d      = base_q;
            for (int i = 0; i < SLOTS; i++) cache_d[i] = '0;
          end else begin
            cache_d[slot_q] = queue_data[PIXEL_W-1:0];
            slot_d          = slot_q + 1'b1;
            cnt_d           = cnt_q + 1'b1;
            if (slot_q == SLOT_W'(SLOTS - 1) || cnt_q == CNT_W'(TOTAL - 1)) state_d = REQ;
          end
        end
      end
      REQ: begin
        write_rq = 1'b1;
        if (write_ack) begin
          widx_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        write_rq   = 1'b1;
        mem_wr_en  = 1'b1;
        write_data = word_sel;
        widx_d     = widx_q + 1'b1;
        if (widx_q == WIDX_W'(BURST_WORDS - 1)) begin
          tcnt_d  = '0;
          state_d = TAIL;
        end
      end
      TAIL: begin
        write_rq = 1'b1;
        tcnt_d   = tcnt_q + 1'b1;
        if (tcnt_q == TCNT_W'(TCMD - 1)) begin
          addr_d  = addr_q + ADDR_W'(BURST_WORDS);
          slot_d  = '0;
          for (int i = 0; i < SLOTS; i++) cache_d[i] = '0;
          state_d = (cnt_q == CNT_W'(TOTAL)) ? DONE : FILL;
        end
      end
      DONE: begin
        upload_done = 1'b1;
        done_buf    = cur_buf_q;
        done_buf_d  = cur_buf_q;
        cur_buf_d   = (cur_buf_q == 3'(NUM_BUFFERS - 1)) ? 3'd0 : cur_buf_q + 3'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      base_q     <= '0;
      slot_q     <= '0;
      cnt_q      <= '0;
      widx_q     <= '0;
      tcnt_q     <= '0;
      cur_buf_q  <= '0;
      done_buf_q <= '0;
      for (int i = 0; i < SLOTS; i++) cache_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      widx_q     <= widx_d;
      tcnt_q     <= tcnt_d;
      cur_buf_q  <= cur_buf_d;
      done_buf_q <= done_buf_d;
      cache_q    <= cache_d;
    end
  end

`ifdef FRAME_UPLOADER_STATS_EN
  logic [15:0] ok_q, aborted_q;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ok_q      <= '0;
      aborted_q <= '0;
    end else begin
      if (upload_done && ok_q != 16'hFFFF) ok_q <= ok_q + 16'd1;
      if (frame_error && aborted_q != 16'hFFFF) aborted_q <= aborted_q + 16'd1;
    end
  end

  assign frames_ok      = ok_q;
  assign frames_aborted = aborted_q;
`else
  assign frames_ok      = '0;
  assign frames_aborted = '0;
`endif

endmodule

// File: tb/tb_frame_uploader_mb.sv
// Bench for frame_uploader_mb: directed frame table, abort/stall/reset sequences, randomized frames
// against a queue-based frame model, and a short-frame padding case on a second instance.
module tb_frame_uploader_mb;
  localparam int PW  = 16;
  localparam int BW  = 4;
  localparam int FW  = 8;
  localparam int FH  = 2;
  localparam int TOT = FW * FH;
  localparam int NB  = 2;
  localparam int AW  = 21;
  localparam int TC  = 3;
  localparam logic [AW-1:0] BASE   = 21'h100;
  localparam logic [AW-1:0] STRIDE = 21'h40;
  localparam logic [PW:0]   MARK   = 17'h10000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic            start, queue_empty, write_ack;
  logic [PW:0]     queue_data;
  logic            rd_en, write_rq, mem_wr_en, upload_done, frame_error;
  logic [AW-1:0]   write_addr;
  logic [2*PW-1:0] write_data;
  logic [2:0]      done_buf, dbg_state;
  logic [15:0]     frames_ok, frames_aborted;

  logic            start5, qe5, ack5;
  logic [PW:0]     qd5;
  logic            rd5, rq5, wr5, done5, err5;
  logic [AW-1:0]   addr5;
  logic [2*PW-1:0] wd5;
  logic [2:0]      dbuf5, st5;
  logic [15:0]     ok5, ab5;

  frame_uploader_mb #(.PIXEL_W(PW), .BURST_WORDS(BW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH),
                      .NUM_BUFFERS(NB), .ADDR_W(AW), .TCMD(TC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(BASE), .buf_stride(STRIDE),
    .queue_empty(queue_empty), .queue_data(queue_data), .rd_en(rd_en), .write_rq(write_rq),
    .write_ack(write_ack), .write_addr(write_addr), .mem_wr_en(mem_wr_en), .write_data(write_data),
    .upload_done(upload_done), .done_buf(done_buf), .frame_error(frame_error),
    .frames_ok(frames_ok), .frames_aborted(frames_aborted), .dbg_state(dbg_state));

  frame_uploader_mb #(.PIXEL_W(PW), .BURST_WORDS(BW), .FRAME_WIDTH(5), .FRAME_HEIGHT(1),
                      .NUM_BUFFERS(NB), .ADDR_W(AW), .TCMD(TC)) dut5 (
    .clk(clk), .reset_n(reset_n), .start(start5), .base_addr(BASE), .buf_stride(STRIDE),
    .queue_empty(qe5), .queue_data(qd5), .rd_en(rd5), .write_rq(rq5),
    .write_ack(ack5), .write_addr(addr5), .mem_wr_en(wr5), .write_data(wd5),
    .upload_done(done5), .done_buf(dbuf5), .frame_error(err5),
    .frames_ok(ok5), .frames_aborted(ab5), .dbg_state(st5));

  int n_checks = 0;
  int n_errors = 0;

  // queue model, stimulus, scoreboard
  logic [PW:0]     fifo[$], pending[$], stim[$];
  logic [AW-1:0]   obs_addr[$], exp_addr[$];
  logic [2*PW-1:0] obs_data[$], exp_q[$];
  logic [2:0]      obs_done[$], exp_done[$];
  int obs_err, exp_err, exp_ok, exp_ab, tb_buf, cur_lat;
  int pre, words, tail, wait_cnt;
  bit trickle, in_rq, done_seen;

  typedef struct {
    int            ack_lat;
    bit            trk;
    logic [AW-1:0] exp_base;
    logic [2:0]    exp_buf;
    logic [31:0]   exp_w0;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    queue_empty = (fifo.size() == 0);
    queue_data  = (fifo.size() > 0) ? fifo[0] : '0;
  endtask

  task automatic add(input logic [PW:0] e);
    pending.push_back(e);
    stim.push_back(e);
  endtask

  task automatic add_frame(input bit seq);
    add(MARK);
    for (int i = 0; i < TOT; i++) add(seq ? 17'(i + 1) : {1'b0, 16'($urandom)});
  endtask

  // Reference: a frame is the pixels after the last marker; every 2*BW pixels (or frame end) form a burst.
  task automatic model_frame(input int bufi);
    logic [PW-1:0] pix[$];
    logic [AW-1:0] fbase;
    int bi, seen;
    bit synced;
    fbase = BASE + AW'(bufi) * STRIDE;
    bi = 0; seen = 0; synced = 0;
    foreach (stim[i]) begin
      if (!synced) begin
        if (stim[i][PW]) synced = 1;
      end else if (stim[i][PW]) begin
        pix.delete(); bi = 0; seen = 0; exp_err++;
      end else begin
        pix.push_back(stim[i][PW-1:0]);
        seen++;
        if (pix.size() == 2 * BW || seen == TOT) begin
          while (pix.size() < 2 * BW) pix.push_back('0);
          exp_addr.push_back(fbase + AW'(bi * BW));
          for (int k = 0; k < BW; k++) exp_q.push_back({pix[2*k+1], pix[2*k]});
          pix.delete();
          bi++;
          if (seen == TOT) break;
        end
      end
    end
    exp_done.push_back(3'(bufi));
    stim.delete();
  endtask

  // Driver / monitor for one clock: sample at negedge, consume and refill the queue after posedge.
  task automatic step();
    bit pop_flag;
    @(negedge clk);
    if (rd_en) begin
      chk("rd_en_nonempty", queue_empty, 1'b0);
      chk("rd_en_no_rq", write_rq, 1'b0);
    end
    if (mem_wr_en) chk("wr_inside_rq", write_rq, 1'b1);
    if (frame_error) obs_err++;
    if (upload_done) begin
      obs_done.push_back(done_buf);
      done_seen = 1'b1;
    end
    if (write_rq) begin
      if (!in_rq) begin
        in_rq = 1; pre = 0; words = 0; tail = 0;
      end
      if (mem_wr_en) begin
        if (words == 0) obs_addr.push_back(write_addr);
        obs_data.push_back(write_data);
        words++;
      end else if (words == 0) pre++;
      else tail++;
    end else if (in_rq) begin
      in_rq = 0;
      chk("burst_words", words, BW);
      chk("tail_cycles", tail, TC);
      chk("req_wait", pre, cur_lat + 1);
    end
    if (!write_rq) begin
      wait_cnt = 0; write_ack = 1'b0;
    end else begin
      write_ack = (wait_cnt >= cur_lat); wait_cnt++;
    end
    pop_flag = rd_en;
    @(posedge clk); #1;
    if (pop_flag && fifo.size() > 0) void'(fifo.pop_front());
    if (!trickle) while (pending.size() > 0) fifo.push_back(pending.pop_front());
    else if (pending.size() > 0 && $urandom_range(0, 1) == 1) fifo.push_back(pending.pop_front());
    refresh();
  endtask

  task automatic run_frame(input int lat, input bit trk);
    cur_lat = lat; trickle = trk; done_seen = 0; obs_err = 0;
    model_frame(tb_buf);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 600 && !done_seen; c++) step();
    chk("frame_done", done_seen, 1'b1);
    tb_buf = (tb_buf + 1) % NB;
    exp_ok++;
  endtask

  task automatic check_frame();
    chk("err_pulses", obs_err, exp_err);
    exp_ab += exp_err; exp_err = 0;
    chk("burst_count", obs_addr.size(), exp_addr.size());
    while (exp_addr.size() > 0) begin
      logic [AW-1:0] a = exp_addr.pop_front();
      if (obs_addr.size() > 0) chk("burst_addr", obs_addr.pop_front(), a);
    end
    chk("word_count", obs_data.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      logic [2*PW-1:0] d = exp_q.pop_front();
      if (obs_data.size() > 0) chk("burst_word", obs_data.pop_front(), d);
    end
    chk("done_count", obs_done.size(), exp_done.size());
    while (exp_done.size() > 0) begin
      logic [2:0] b = exp_done.pop_front();
      if (obs_done.size() > 0) chk("done_buf", obs_done.pop_front(), b);
    end
    obs_addr.delete(); obs_data.delete(); obs_done.delete();
`ifdef FRAME_UPLOADER_STATS_EN
    chk("frames_ok", frames_ok, exp_ok);
    chk("frames_aborted", frames_aborted, exp_ab);
`else
    chk("frames_ok", frames_ok, 0);
    chk("frames_aborted", frames_aborted, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [PW:0]     q5[6];
    logic [2*PW-1:0] exp5[4];
    logic [2*PW-1:0] d5q[$];
    int idx5;
    bit p5, got5;

    reset_n = 1'b0; start = 1'b0; write_ack = 1'b0; trickle = 0; cur_lat = 0;
    start5 = 1'b0; ack5 = 1'b0; qe5 = 1'b1; qd5 = '0;
    obs_err = 0; exp_err = 0; exp_ok = 0; exp_ab = 0; tb_buf = 0;
    in_rq = 0; wait_cnt = 0; done_seen = 0;
    refresh();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_write_rq", write_rq, 0);
    chk("rst_mem_wr_en", mem_wr_en, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_write_addr", write_addr, 0);
    chk("rst_upload_done", upload_done, 0);
    chk("rst_done_buf", done_buf, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_frames_ok", frames_ok, 0);
    chk("rst_frames_aborted", frames_aborted, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed frames: round-robin bases, ack latency and trickled queue
    tbl[0] = '{0,  1'b0, 21'h100, 3'd0, 32'h00020001};
    tbl[1] = '{0,  1'b0, 21'h140, 3'd1, 32'h00020001};
    tbl[2] = '{0,  1'b1, 21'h100, 3'd0, 32'h00020001};
    tbl[3] = '{10, 1'b0, 21'h140, 3'd1, 32'h00020001};
    for (int i = 0; i < 4; i++) begin
      add_frame(1'b1);
      run_frame(tbl[i].ack_lat, tbl[i].trk);
      chk("tbl_bursts", obs_addr.size(), 2);
      if (obs_addr.size() >= 2) begin
        chk("tbl_base", obs_addr[0], tbl[i].exp_base);
        chk("tbl_second", obs_addr[1], tbl[i].exp_base + 21'd4);
      end
      if (obs_data.size() > 0) chk("tbl_word0", obs_data[0], tbl[i].exp_w0);
      if (obs_done.size() > 0) chk("tbl_done_buf", obs_done[0], tbl[i].exp_buf);
      check_frame();
    end

    // Marker after 5 pixels aborts the partial frame
    add(MARK);
    for (int i = 0; i < 5; i++) add(17'(16'hA0 + i));
    add_frame(1'b1);
    run_frame(0, 1'b0);
    chk("abort_pulse", obs_err, 1);
    check_frame();

    // Reset during the third data word of a burst that would target buffer 1
    add_frame(1'b0);
    stim.delete();
    cur_lat = 0; trickle = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 300 && obs_data.size() < 2; c++) step();
    chk("rst_mid_words", obs_data.size(), 2);
    chk("rst_mid_in_data", mem_wr_en, 1'b1);
    reset_n = 1'b0; write_ack = 1'b0;
    #1;
    chk("rst_mid_wr", mem_wr_en, 0);
    chk("rst_mid_rq", write_rq, 0);
    chk("rst_mid_rd", rd_en, 0);
    chk("rst_mid_addr", write_addr, 0);
    chk("rst_mid_data", write_data, 0);
    chk("rst_mid_done", upload_done, 0);
    @(posedge clk); #1;
    chk("rst_hold_wr", mem_wr_en, 0);
    chk("rst_hold_rq", write_rq, 0);
    fifo.delete(); pending.delete(); stim.delete();
    obs_addr.delete(); obs_data.delete(); obs_done.delete();
    in_rq = 0; wait_cnt = 0; obs_err = 0; exp_err = 0; exp_ok = 0; exp_ab = 0; tb_buf = 0;
    refresh();
    @(negedge clk);
    reset_n = 1'b1;
    add_frame(1'b1);
    run_frame(0, 1'b0);
    chk("rst_new_base", (obs_addr.size() > 0) ? obs_addr[0] : '1, BASE);
    check_frame();

    // Randomized frames: leading junk, optional aborted prefix, random ack latency and queue rate
    for (int r = 0; r < 10; r++) begin
      int junk = $urandom_range(0, 2);
      for (int j = 0; j < junk; j++) add({1'b0, 16'($urandom)});
      if ($urandom_range(0, 2) == 0) begin
        int k = $urandom_range(1, TOT - 1);
        add(MARK);
        for (int j = 0; j < k; j++) add({1'b0, 16'($urandom)});
      end
      add_frame(1'b0);
      run_frame($urandom_range(0, 4), 1'($urandom_range(0, 1)));
      check_frame();
    end

    // 5x1 frame: a single zero-padded burst on the second instance
    q5[0] = MARK; q5[1] = 17'h11; q5[2] = 17'h12; q5[3] = 17'h13; q5[4] = 17'h14; q5[5] = 17'h15;
    exp5[0] = 32'h00120011; exp5[1] = 32'h00140013; exp5[2] = 32'h00000015; exp5[3] = 32'h0;
    idx5 = 0; got5 = 0;
    qe5 = 1'b0; qd5 = q5[0];
    start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    for (int c = 0; c < 80 && !got5; c++) begin
      @(negedge clk);
      if (rd5) chk("b5_rd_nonempty", qe5, 1'b0);
      if (wr5) begin
        if (d5q.size() == 0) chk("b5_addr", addr5, BASE);
        d5q.push_back(wd5);
      end
      if (err5) chk("b5_err", err5, 1'b0);
      if (done5) begin
        got5 = 1;
        chk("b5_done_buf", dbuf5, 0);
      end
      p5 = rd5; ack5 = rq5;
      @(posedge clk); #1;
      if (p5) idx5++;
      qe5 = (idx5 >= 6);
      qd5 = (idx5 < 6) ? q5[idx5] : '0;
    end
    chk("b5_done", got5, 1'b1);
    chk("b5_words", d5q.size(), 4);
    for (int i = 0; i < 4; i++) if (i < d5q.size()) chk("b5_word", d5q[i], exp5[i]);
    chk("b5_idle", st5, 0);
`ifdef FRAME_UPLOADER_STATS_EN
    chk("b5_ok", ok5, 1);
    chk("b5_aborted", ab5, 0);
`else
    chk("b5_ok", ok5, 0);
    chk("b5_aborted", ab5, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/frame_uploader_mb.md
FRAME_UPLOADER_MB -- requirements
Module: frame_uploader_mb

Interface
REQ-001 SHALL have parameter PIXEL_W, default 16, pixel payload width.
REQ-002 SHALL have parameter BURST_WORDS, default 8, WORD_W-bit words per memory burst (2 pixels/word).
REQ-003 SHALL have parameter FRAME_WIDTH, default 640; FRAME_HEIGHT, default 480; pixels per frame = product.
REQ-004 SHALL have parameter NUM_BUFFERS, default 2 (1..8), frame buffers rotated round-robin.
REQ-005 SHALL have parameter ADDR_W, default 21, word-address width; TCMD, default 19, post-burst command cycles.
REQ-006 SHALL define WORD_W = 2*PIXEL_W (derived, not overridable).
REQ-007 clk  input  1  clock; all logic on rising edge.
REQ-008 reset_n  input  1  reset, asynchronous, active-low.
REQ-009 start  input  1  single-cycle request to upload one frame.
REQ-010 base_addr, buf_stride  input  ADDR_W each  buffer 0 word address; word spacing between buffers.
REQ-011 queue_empty  input  1; queue_data  input  PIXEL_W+1  show-ahead queue; bit PIXEL_W = frame-start marker.
REQ-012 rd_en  output  1  combinational pop; entry consumed in the same cycle.
REQ-013 write_rq  output  1; write_ack  input  1  memory arbitration handshake.
REQ-014 write_addr  output  ADDR_W; mem_wr_en  output  1; write_data  output  WORD_W  burst data.
REQ-015 upload_done  output  1; done_buf  output  3; frame_error  output  1; frames_ok, frames_aborted  output  16 each.

Function
REQ-016 FSM states SHALL be IDLE, SYNC, FILL, REQ, DATA, TAIL, DONE.
REQ-017 IDLE: start=1 -> SYNC, write_addr <= base_addr + cur_buf*buf_stride; start outside IDLE is ignored.
REQ-018 SYNC: rd_en = !queue_empty; non-marker entries discarded; marker entry -> FILL, pixel count 0.
REQ-019 FILL: rd_en = !queue_empty; each pixel goes into a 2*BURST_WORDS-slot cache, even pixel in word[PIXEL_W-1:0], odd pixel in upper half.
REQ-020 FILL -> REQ when cache full or frame pixel count reached; the final partial burst is zero-padded to BURST_WORDS.
REQ-021 A marker in FILL SHALL discard the cache, pulse frame_error one cycle, restart count at 0 at the same write_addr base, and stay in FILL.
REQ-022 REQ: write_rq=1 until write_ack=1 -> DATA; write_rq stays 1 through DATA and TAIL.
REQ-023 DATA: mem_wr_en=1 for exactly BURST_WORDS consecutive cycles starting the cycle after ack; write_data = cache words 0..BURST_WORDS-1 in order.
REQ-024 TAIL: exactly TCMD cycles; then write_rq=0, write_addr += BURST_WORDS (mod 2^ADDR_W); -> DONE if frame complete, else FILL.
REQ-025 DONE: upload_done=1 for one cycle, done_buf = cur_buf, cur_buf = (cur_buf+1) mod NUM_BUFFERS, -> IDLE.
REQ-026 rd_en SHALL be 0 in IDLE, REQ, DATA, TAIL, and DONE; the queue is never popped while empty.
REQ-027 Address arithmetic SHALL be ADDR_W bits, overflow wraps silently.

Reset
REQ-028 On reset_n=0: state IDLE, cur_buf 0, cache cleared, and all outputs 0 (rd_en, write_rq, mem_wr_en, write_data, write_addr, upload_done, done_buf, frame_error, counters).
REQ-029 Reset asserted mid-burst SHALL drop mem_wr_en and write_rq immediately; no resume after release.

Configuration
REQ-030 Macro FRAME_UPLOADER_STATS_EN defined: frames_ok increments on each DONE; frames_aborted increments on each frame_error; both saturate at 16'hFFFF.
REQ-031 Macro FRAME_UPLOADER_STATS_EN undefined: frames_ok and frames_aborted tied to 0, no counter logic; all other behaviour identical.

Verification
REQ-032 Use FRAME_WIDTH=8, FRAME_HEIGHT=2, BURST_WORDS=4, TCMD=3, base_addr=0x100, buf_stride=0x40 for the scenarios below.
REQ-033 Push marker+16 pixels 0x0001..0x0010, ack at once -> 2 bursts at 0x100, 0x104; first word 0x00020001; upload_done once, done_buf=0.
REQ-034 Repeat the frame 3 times with NUM_BUFFERS=2 -> base addresses 0x100, 0x140, 0x100; done_buf 0, 1, 0.
REQ-035 Marker after 5 pixels, then 16 pixels -> one frame_error pulse, no burst for the aborted pixels, frames_aborted=1 with STATS_EN.
REQ-036 Hold write_ack low 10 cycles in REQ -> write_rq steady, rd_en=0, no mem_wr_en; DATA starts the cycle after ack.
REQ-037 FRAME_WIDTH=5, FRAME_HEIGHT=1 -> one burst: words {p1,p0}, {p3,p2}, {0,p4}, 0.
REQ-038 reset_n low during DATA word 2 -> all outputs 0 next edge; a new start uploads to 0x100.
